// File: rtl/reg_write_arbiter_if.sv
// reg_write_arbiter_if: bundles the requester handshake and the shared
// register write port of reg_write_arbiter.
//   master : the environment side (requesters plus the shared register)
//   slave  : the arbiter itself
interface reg_write_arbiter_if #(
  parameter int NREQ = 4
);
  // Requester side
  logic [NREQ-1:0]      req;       // level request, held until gnt
  logic [32*NREQ-1:0]   req_data;  // requester i owns bits [32*i +: 32]
  logic [NREQ-1:0]      gnt;       // one-hot, one-cycle completion ack
  logic                 busy;      // arbiter is not idle
  logic                 err;       // valid check timed out (with gnt)

  // Shared register side
  logic [31:0]          reg_d;     // register d input
  logic                 reg_en;    // register en input
  logic                 reg_valid; // register valid output

  modport master (
    output req, req_data, reg_valid,
    input  gnt, busy, err, reg_d, reg_en
  );

  modport slave (
    input  req, req_data, reg_valid,
    output gnt, busy, err, reg_d, reg_en
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: shares the write port of one 32-bit register among NREQ
// requesters. A winner is picked in IDLE, its data is latched and written with
// a one-cycle enable, the register's valid flag is awaited (bounded by
// TIMEOUT cycles), and a one-cycle gnt (plus err on timeout) is returned.
//
// Build option: define REG_ARB_FIXED_PRIO_EN for fixed priority (lowest
// asserted index wins, round-robin pointer frozen). Default is round-robin.
module reg_write_arbiter #(
  parameter int NREQ    = 4,  // number of requesters, 2..8
  parameter int TIMEOUT = 4   // CHECK cycles before giving up, 1..15
) (
  input  logic          clk,
  input  logic          rst,
  reg_write_arbiter_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0]   LAST_INIT   = PW'(NREQ - 1);
  localparam logic [3:0]      TIMEOUT_CNT = 4'(TIMEOUT);
  localparam logic [NREQ-1:0] ONE_HOT0    = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CHECK = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       data_q,  data_d;   // latched write data of the winner
  logic [PW-1:0]     win_q,   win_d;    // index of the current winner
  logic [PW-1:0]     last_q,  last_d;   // round-robin pointer (last winner)
  logic [3:0]        cnt_q,   cnt_d;    // CHECK cycle counter, saturating
  logic [NREQ-1:0]   gnt_q,   gnt_d;
  logic              err_q,   err_d;

  logic [PW-1:0]     pick;              // arbitration result this cycle
  logic [PW-1:0]     scan;
  logic [3:0]        cnt_inc;

  // Per-requester 32-bit words carved out of the packed data bus
  logic [31:0]       req_word [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign req_word[gi] = bus.req_data[32*gi +: 32];
  end

  // Arbitration: choose the winning index among the asserted requests.
  // The loop runs from lowest to highest priority so that the last match
  // (the highest-priority asserted request) is what remains in pick.
  always_comb begin
    pick = last_q;
    scan = '0;
`ifdef REG_ARB_FIXED_PRIO_EN
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan = PW'(k);
      if (bus.req[scan]) begin
        pick = scan;
      end
    end
`else
    // Scan order last+1, last+2, ... wrapping modulo NREQ; k=1 is the
    // highest priority, so it is visited last.
    for (int k = NREQ; k >= 1; k--) begin
      scan = PW'((int'(last_q) + k) % NREQ);
      if (bus.req[scan]) begin
        pick = scan;
      end
    end
`endif
  end

  // Next-state and registered-output logic of the write sequencer
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    win_d   = win_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    err_d   = 1'b0;
    cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

    unique case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          data_d  = req_word[pick];
          win_d   = pick;
`ifndef REG_ARB_FIXED_PRIO_EN
          last_d  = pick;
`endif
          state_d = ST_WRITE;
        end
      end

      ST_WRITE: begin
        // reg_en is decoded from this state; start the valid wait fresh
        cnt_d   = '0;
        state_d = ST_CHECK;
      end

      ST_CHECK: begin
        if (bus.reg_valid) begin
          gnt_d   = ONE_HOT0 << win_q;
          err_d   = 1'b0;
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_CNT) begin
            // Give up waiting; still acknowledge the winner, flag the error
            gnt_d   = ONE_HOT0 << win_q;
            err_d   = 1'b1;
            state_d = ST_ACK;
          end
        end
      end

      ST_ACK: begin
        // gnt/err are high for this single cycle; arbitration resumes next
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; reset aborts any transaction in flight without a gnt
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      win_q   <= '0;
      last_q  <= LAST_INIT;
      cnt_q   <= '0;
      gnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      win_q   <= win_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
    end
  end

  // reg_d always reflects the latched data, so it holds its value while idle
  assign bus.reg_d  = data_q;
  assign bus.reg_en = (state_q == ST_WRITE);
  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.gnt    = gnt_q;
  assign bus.err    = err_q;

  // Structural invariants of the handshake
  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(bus.gnt));
  a_err_with_gnt: assert property (@(posedge clk) disable iff (rst)
    bus.err |-> (|bus.gnt));
  a_en_single: assert property (@(posedge clk) disable iff (rst)
    bus.reg_en |=> !bus.reg_en);
  a_gnt_single: assert property (@(posedge clk) disable iff (rst)
    (|bus.gnt) |=> (bus.gnt == '0));

endmodule
